// File: rtl/sfq_and_n_model.sv
`default_nettype none
// ============================================================================
// Module   : sfq_and_n_model
// Purpose  : Cycle-based behavioural model of a clocked SFQ gate with N
//            toggle-encoded data inputs. The gate function is AND or OR,
//            selected by MODE. The model has a programmable output delay,
//            hold-window checking, duplicate-pulse detection and a
//            saturating violation counter.
// Ports    : clk         - system sampling clock (rising edge)
//            rst_n       - synchronous active-low reset
//            in_tgl      - N toggle-encoded data pulse lines
//            gclk_tgl    - toggle-encoded gate-clock pulse line
//            out_tgl     - toggle-encoded output pulse line
//            arrived     - data inputs received in the current window
//            state_valid - 0 once a duplicate pulse drives the gate INVALID
//            err_dup     - sticky duplicate-pulse error
//            err_hold    - sticky hold-violation error
//            viol_cnt    - saturating count of hold-violation cycles
// Revision : 1.0 - initial release
// ============================================================================
module sfq_and_n_model #(
  parameter int N         = 2,
  parameter int HOLD_CYC  = 3,
  parameter int DELAY_CYC = 6,
  parameter int MODE      = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_tgl,
  input  logic             gclk_tgl,
  output logic             out_tgl,
  output logic [N-1:0]     arrived,
  output logic             state_valid,
  output logic             err_dup,
  output logic             err_hold,
  output logic [CNT_W-1:0] viol_cnt
);

  typedef enum logic [0:0] {
    ST_ARMED   = 1'b0,
    ST_INVALID = 1'b1
  } state_t;

  localparam logic [3:0] c_HOLD_INIT = 4'(HOLD_CYC);

  // Previous input samples used for edge (pulse) detection
  logic [N-1:0]         r_in_q;
  logic                 r_gclk_q;

  state_t               r_state;
  state_t               w_state_next;
  logic [N-1:0]         r_arrived;
  logic [N-1:0]         w_arrived_next;
  logic [3:0]           r_hold_cnt;
  logic [3:0]           w_hold_next;
  logic                 r_out;
  logic                 r_err_dup;
  logic                 r_err_hold;
  logic [CNT_W-1:0]     r_viol_cnt;
  logic [DELAY_CYC-1:0] r_pipe;
  logic [DELAY_CYC-1:0] w_pipe_next;

  logic [N-1:0]         w_p;
  logic                 w_g;
  logic                 w_fire;
  logic                 w_dup;
  logic                 w_hold_viol;
  logic                 w_pipe_out;

  assign w_p        = in_tgl ^ r_in_q;
  assign w_g        = gclk_tgl ^ r_gclk_q;
  assign w_pipe_out = r_pipe[DELAY_CYC-1];

  // Hold checking is independent of the FSM state: it keeps running
  // after the gate has gone INVALID.
  assign w_hold_viol = (|w_p) && (w_g || (r_hold_cnt != 4'd0));

  // Fire enters the low end of the shift pipeline and exits DELAY_CYC
  // edges later.
  generate
    if (DELAY_CYC == 1) begin : g_pipe_single
      assign w_pipe_next = w_fire;
    end else begin : g_pipe_shift
      assign w_pipe_next = {r_pipe[DELAY_CYC-2:0], w_fire};
    end
  endgenerate

  // Next-state / datapath decode
  always_comb begin
    w_state_next   = r_state;
    w_arrived_next = r_arrived;
    w_hold_next    = r_hold_cnt;
    w_fire         = 1'b0;
    w_dup          = 1'b0;

    if (!w_g && (r_hold_cnt != 4'd0)) begin
      w_hold_next = r_hold_cnt - 4'd1;
    end

    case (r_state)
      ST_ARMED: begin
        if (w_g) begin
          // The gate evaluates the window closed by this clock. Data
          // pulses arriving in the same cycle open the next window.
          w_fire         = (MODE == 0) ? (&r_arrived) : (|r_arrived);
          w_arrived_next = w_p;
          w_hold_next    = c_HOLD_INIT;
        end else if (|(w_p & r_arrived)) begin
          w_dup          = 1'b1;
          w_state_next   = ST_INVALID;
          w_arrived_next = '0;
        end else begin
          w_arrived_next = r_arrived | w_p;
        end
      end
      ST_INVALID: begin
        w_arrived_next = '0;
      end
      default: begin
        w_state_next   = ST_ARMED;
        w_arrived_next = '0;
      end
    endcase
  end

  // State register and sequential datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Track the live inputs so that no pulse appears after release
      r_in_q     <= in_tgl;
      r_gclk_q   <= gclk_tgl;
      r_state    <= ST_ARMED;
      r_arrived  <= '0;
      r_hold_cnt <= 4'd0;
      r_out      <= 1'b0;
      r_err_dup  <= 1'b0;
      r_err_hold <= 1'b0;
      r_viol_cnt <= '0;
      r_pipe     <= '0;
    end else begin
      r_in_q     <= in_tgl;
      r_gclk_q   <= gclk_tgl;
      r_state    <= w_state_next;
      r_arrived  <= w_arrived_next;
      r_hold_cnt <= w_hold_next;
      r_err_dup  <= r_err_dup | w_dup;
      r_err_hold <= r_err_hold | w_hold_viol;
      if (w_hold_viol && (r_viol_cnt != '1)) begin
        r_viol_cnt <= r_viol_cnt + 1'b1;
      end
      // An invalid gate drops all in-flight pulses
      if (w_state_next == ST_INVALID) begin
        r_pipe <= '0;
      end else begin
        r_pipe <= w_pipe_next;
      end
      if ((r_state == ST_ARMED) && w_pipe_out) begin
        r_out <= ~r_out;
      end
    end
  end

  assign out_tgl     = r_out;
  assign arrived     = r_arrived;
  assign state_valid = (r_state == ST_ARMED);
  assign err_dup     = r_err_dup;
  assign err_hold    = r_err_hold;
  assign viol_cnt    = r_viol_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sfq_and_n_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfq_and_n_model
// Purpose  : Self-checking bench for sfq_and_n_model. An AND instance and an
//            OR instance share the same stimulus. A table of per-edge
//            vectors drives them, and hand sequences cover mid-run reset
//            and counter saturation.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sfq_and_n_model;

  typedef struct {
    bit         rst;      // reset both models before this row
    int         cyc;      // edge number (after reset release) to check at
    logic [1:0] in_flip;  // data lines toggled before that edge
    logic       g_flip;   // gate clock toggled before that edge
    logic       e_out_a;
    logic       e_out_o;
    logic [1:0] e_arr;
    logic       e_valid;
    logic       e_dup;
    logic       e_hold;
    logic [7:0] e_viol;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] in_tgl;
  logic       gclk_tgl;

  logic       out_a, out_o;
  logic [1:0] arr_a, arr_o;
  logic       val_a, val_o, dup_a, dup_o, hold_a, hold_o;
  logic [7:0] vc_a, vc_o;

  int checks   = 0;
  int failures = 0;
  int ec       = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  sfq_and_n_model #(.N(2), .HOLD_CYC(3), .DELAY_CYC(6), .MODE(0), .CNT_W(8)) dut_and (
    .clk(clk), .rst_n(rst_n), .in_tgl(in_tgl), .gclk_tgl(gclk_tgl),
    .out_tgl(out_a), .arrived(arr_a), .state_valid(val_a),
    .err_dup(dup_a), .err_hold(hold_a), .viol_cnt(vc_a)
  );

  sfq_and_n_model #(.N(2), .HOLD_CYC(3), .DELAY_CYC(6), .MODE(1), .CNT_W(8)) dut_or (
    .clk(clk), .rst_n(rst_n), .in_tgl(in_tgl), .gclk_tgl(gclk_tgl),
    .out_tgl(out_o), .arrived(arr_o), .state_valid(val_o),
    .err_dup(dup_o), .err_hold(hold_o), .viol_cnt(vc_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
    ec++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    ec = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit rst, input int cyc, input logic [1:0] fl, input logic gf,
                     input logic eoa, input logic eoo, input logic [1:0] ea,
                     input logic ev, input logic ed, input logic eh, input logic [7:0] evc);
    vec_t v;
    v.rst = rst; v.cyc = cyc; v.in_flip = fl; v.g_flip = gf;
    v.e_out_a = eoa; v.e_out_o = eoo; v.e_arr = ea;
    v.e_valid = ev; v.e_dup = ed; v.e_hold = eh; v.e_viol = evc;
    vecs.push_back(v);
  endtask

  task automatic check_row(input int i, input vec_t v);
    string t;
    t = $sformatf("row%0d@%0d", i, v.cyc);
    chk({t, " out_and"},   32'(out_a),  32'(v.e_out_a));
    chk({t, " out_or"},    32'(out_o),  32'(v.e_out_o));
    chk({t, " arr_and"},   32'(arr_a),  32'(v.e_arr));
    chk({t, " arr_or"},    32'(arr_o),  32'(v.e_arr));
    chk({t, " valid_and"}, 32'(val_a),  32'(v.e_valid));
    chk({t, " valid_or"},  32'(val_o),  32'(v.e_valid));
    chk({t, " dup_and"},   32'(dup_a),  32'(v.e_dup));
    chk({t, " dup_or"},    32'(dup_o),  32'(v.e_dup));
    chk({t, " hold_and"},  32'(hold_a), 32'(v.e_hold));
    chk({t, " hold_or"},   32'(hold_o), 32'(v.e_hold));
    chk({t, " viol_and"},  32'(vc_a),   32'(v.e_viol));
    chk({t, " viol_or"},   32'(vc_o),   32'(v.e_viol));
  endtask

  initial begin
    rst_n    = 1'b0;
    in_tgl   = 2'b00;
    gclk_tgl = 1'b0;

    //    rst  cyc  in    g    oA   oO   arr    val  dup  hold viol
    // Basic AND window: both inputs, then gate clock, output 6 edges later
    add(1'b1,  1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b0, 10, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b0, 12, 2'b10, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b0, 20, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b0, 25, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b0, 26, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 8'd0);
    // One input only: AND stays quiet, OR fires
    add(1'b1, 10, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b0, 20, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b0, 25, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b0, 26, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 8'd0);
    // Empty-window gate clock, hold violations and hold-window edges
    add(1'b1, 20, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b0, 22, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 8'd1);
    add(1'b0, 30, 2'b01, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 8'd1);
    add(1'b0, 40, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 8'd1);
    add(1'b0, 43, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 8'd2);
    add(1'b0, 44, 2'b10, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 8'd2);
    add(1'b0, 45, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 8'd2);
    add(1'b0, 46, 2'b00, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 8'd2);
    // Duplicate pulse: gate goes INVALID and ignores later pulses
    add(1'b1, 10, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b0, 14, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0);
    add(1'b0, 20, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0);
    add(1'b0, 27, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0);
    add(1'b0, 30, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 8'd0);
    // Two overlapping fires (gate clock at 20 and 22)
    add(1'b1, 10, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b0, 12, 2'b10, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 8'd0);
    add(1'b0, 20, 2'b11, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1, 8'd1);
    add(1'b0, 22, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 8'd1);
    add(1'b0, 25, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 8'd1);
    add(1'b0, 26, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 8'd1);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      while (ec < vecs[i].cyc - 1) step();
      in_tgl   = in_tgl ^ vecs[i].in_flip;
      gclk_tgl = gclk_tgl ^ vecs[i].g_flip;
      step();
      check_row(i, vecs[i]);
    end

    // Reset at edge 27 drops the second in-flight fire due at edge 28
    rst_n = 1'b0;
    step();
    chk("midrst out_and",  32'(out_a), 32'd0);
    chk("midrst out_or",   32'(out_o), 32'd0);
    chk("midrst viol_and", 32'(vc_a),  32'd0);
    chk("midrst hold_and", 32'(hold_a), 32'd0);
    chk("midrst valid_and", 32'(val_a), 32'd1);
    rst_n = 1'b1;
    step();
    chk("postrst28 out_and", 32'(out_a), 32'd0);
    chk("postrst28 out_or",  32'(out_o), 32'd0);
    step();
    chk("postrst29 out_and", 32'(out_a), 32'd0);

    // Violation counter saturation: simultaneous data + gate clock each edge
    do_reset();
    for (int k = 0; k < 254; k++) begin
      in_tgl   = in_tgl ^ 2'b01;
      gclk_tgl = ~gclk_tgl;
      step();
    end
    chk("sat254 viol_and", 32'(vc_a), 32'd254);
    chk("sat254 viol_or",  32'(vc_o), 32'd254);
    for (int k = 0; k < 46; k++) begin
      in_tgl   = in_tgl ^ 2'b01;
      gclk_tgl = ~gclk_tgl;
      step();
    end
    chk("sat300 viol_and",  32'(vc_a),   32'd255);
    chk("sat300 viol_or",   32'(vc_o),   32'd255);
    chk("sat300 hold_and",  32'(hold_a), 32'd1);
    chk("sat300 valid_and", 32'(val_a),  32'd1);
    chk("sat300 dup_and",   32'(dup_a),  32'd0);
    chk("sat300 out_and",   32'(out_a),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sfq_and_n_model.md
Name: sfq_and_n_model

Overview:
Cycle-based behavioural model of a clocked SFQ gate with N data inputs, selectable AND or OR function, and a programmable output delay.
- All pulses are toggle-encoded: every edge on an input is one pulse. Inputs are sampled on a single system clock.
- Includes hold-window checking, detection of duplicate pulses into an invalid state, and violation counting.
- Used as the parametrised gate model in timing-assertion benches. It replaces fixed 2-input event-driven models.

Parameters:
- N, 2, number of data inputs (2..8).
- HOLD_CYC, 3, hold window in clk cycles after a gate-clock pulse (0..15).
- DELAY_CYC, 6, gate-clock-to-output latency in clk cycles (1..32).
- MODE, 0, 0 = AND (fire when all inputs arrived), 1 = OR (fire when any input arrived).
- CNT_W, 8, width of the violation counter.

Ports:
- clk, in, 1, system sampling clock; all logic on rising edge.
- rst_n, in, 1, synchronous active-low reset.
- in_tgl, in, N, toggle-encoded data pulses.
- gclk_tgl, in, 1, toggle-encoded gate-clock pulse.
- out_tgl, out, 1, toggle-encoded output pulse.
- arrived, out, N, data inputs received in the current window.
- state_valid, out, 1, 0 once the model enters INVALID.
- err_dup, out, 1, sticky duplicate-pulse error.
- err_hold, out, 1, sticky hold-violation error.
- viol_cnt, out, CNT_W, count of hold-violation cycles, saturating.

Behaviour:
- Interface is fixed: one clock (clk); reset is synchronous and active-low (rst_n).
- Edge detect:
  - Registers in_q and gclk_q hold the previous samples.
  - Pulse vector p = in_tgl ^ in_q; gate-clock pulse g = gclk_tgl ^ gclk_q.
  - During reset, in_q and gclk_q load the current inputs, so there is no spurious pulse after reset release.
- Reset values: out_tgl = 0, arrived = 0, state_valid = 1, err_dup = 0, err_hold = 0, viol_cnt = 0, hold_cnt = 0, delay pipeline flushed, state = ARMED.
- State machine has two states, ARMED and INVALID.
  - ARMED → INVALID when any p[i] = 1 while arrived[i] = 1 and g = 0 (duplicate pulse). Sets err_dup.
  - INVALID → ARMED only via reset.
- In ARMED with g = 0:
  - arrived |= p.
- In ARMED with g = 1:
  - fire = (MODE == 0) ? &arrived : |arrived. The evaluation uses arrived before this cycle's p.
  - arrived <= p. Simultaneous data pulses belong to the next window and count as a hold violation.
  - hold_cnt <= HOLD_CYC.
- When g = 0 and hold_cnt ≠ 0, hold_cnt decrements by 1.
- Hold violation: in any cycle where p ≠ 0 and (g = 1 or hold_cnt ≠ 0):
  - err_hold is set and viol_cnt increments by 1 (once per cycle, regardless of how many bits of p are set).
  - viol_cnt saturates at all-ones.
  - The data pulse is still accepted.
  - With HOLD_CYC = 0, only simultaneous pulses count as violations.
- Output delay:
  - fire is pushed into a DELAY_CYC-deep shift pipeline.
  - out_tgl inverts when a 1 exits the pipeline. A gclk_tgl edge sampled at clk edge k gives an out_tgl change visible after edge k+DELAY_CYC.
  - Overlapping fires are all preserved (one toggle each).
- Gate-clock pulse with an empty window: no fire, no error.
- Entering INVALID:
  - state_valid = 0, arrived cleared, pipeline flushed, out_tgl frozen.
  - Further pulses are ignored, except that hold checking and viol_cnt continue.
- Reset asserted mid-operation flushes in-flight pulses; out_tgl returns to 0 the next edge.

Test Plan:
1. N=2, MODE=0: toggle in_tgl[0] at cycle 10, in_tgl[1] at 12, gclk at 20 → out_tgl 0→1 after edge 26; arrived = 00 after edge 20; no errors.
2. MODE=0, only in_tgl[0] then gclk; separately MODE=1 with the same stimulus → AND: no out_tgl change; OR: out_tgl toggles 6 cycles after gclk.
3. gclk at cycle 20, in_tgl[1] at 22 → err_hold = 1, viol_cnt = 1, arrived = 10. Then in_tgl[0] at 30, gclk at 40 → out_tgl toggles at 46.
4. in_tgl[0] toggled at 10 and again at 14, no gclk → state_valid = 0 and err_dup = 1 after edge 14; later gclk pulses cause no output change.
5. Two fires with gclk at 20 and 22 (inputs reloaded between) → out_tgl toggles at 26 and 28. Assert rst_n at 27 → out_tgl = 0 and no toggle at 28.
6. Drive 300 simultaneous data+gclk cycles with CNT_W = 8 → viol_cnt saturates at 255.
